// File: rtl/sdram_burst_scheduler.sv
// sdram_burst_scheduler
//   Round-robin burst scheduler sitting between NUM_PORTS FIFO channels and a
//   single SDRAM command engine. Each port walks a circular address window
//   [base, max) in bursts of port_len words, clipped at the window end.
//   Write ports need a full burst of data in their FIFO; read ports need a
//   full burst of free space. One burst is in flight at a time.
// Ports:
//   CLK, RESET_N            clock, async active-low reset
//   port_en/load/base/max/len, fifo_usedw   per-port config and FIFO level (packed)
//   cmd_valid/ready/port/wr/addr/len        burst request handshake
//   burst_done              completion pulse for the in-flight burst
//   cur_addr                packed per-port current addresses
//   busy                    scheduler not idle

// Per-port address tracker and eligibility check.
module sdram_burst_port #(
  parameter int ADDR_W     = 23,
  parameter int LEN_W      = 9,
  parameter int USEDW_W    = 10,
  parameter int FIFO_DEPTH = 512,
  parameter bit IS_WR      = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               en,
  input  logic               load,
  input  logic [ADDR_W-1:0]  base,
  input  logic [ADDR_W-1:0]  max,
  input  logic [LEN_W-1:0]   len,
  input  logic [USEDW_W-1:0] usedw,
  input  logic               in_flight,  // this port owns the current burst
  input  logic               upd,        // burst_done for this port's burst
  input  logic [LEN_W-1:0]   burst_len,  // length actually issued
  output logic [ADDR_W-1:0]  cur,
  output logic               elig,
  output logic [LEN_W-1:0]   clip_len
);
  localparam int AX = ADDR_W + 1;
  localparam int CW = (USEDW_W + 1 > LEN_W) ? USEDW_W + 1 : LEN_W;

  logic             pend;
  logic [AX-1:0]    rem, nxt;
  logic [USEDW_W:0] dep, uw, free;
  logic             fifo_ok;

  always_comb begin
    // one extra bit so the all-ones address still detects the wrap
    rem  = {1'b0, max} - {1'b0, cur};
    nxt  = {1'b0, cur} + AX'(burst_len);
    dep  = (USEDW_W+1)'(FIFO_DEPTH);
    uw   = {1'b0, usedw};
    free = (uw > dep) ? '0 : dep - uw;
    fifo_ok  = IS_WR ? (CW'(usedw) >= CW'(len)) : (CW'(free) >= CW'(len));
    // cur<max keeps cmd_len nonzero if the window is reprogrammed under us;
    // a load seen this cycle blocks too, else we'd issue from the stale address
    elig     = en && (len != '0) && (base < max) && (cur < max) &&
               !pend && !load && fifo_ok;
    clip_len = (rem < AX'(len)) ? rem[LEN_W-1:0] : len;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur  <= '0;
      pend <= 1'b0;
    end else if (upd) begin
      cur  <= (pend || load || nxt >= {1'b0, max}) ? base : nxt[ADDR_W-1:0];
      pend <= 1'b0;
    end else if (load) begin
      if (in_flight) pend <= 1'b1;
      else           cur  <= base;
    end
  end
endmodule

module sdram_burst_scheduler #(
  parameter int                   NUM_PORTS  = 4,
  parameter int                   ADDR_W     = 23,
  parameter int                   LEN_W      = 9,
  parameter int                   USEDW_W    = 10,
  parameter int                   FIFO_DEPTH = 512,
  parameter logic [NUM_PORTS-1:0] PORT_IS_WR = 4'b0011,
  localparam int                  PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic [NUM_PORTS-1:0]           port_load,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_base,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_max,
  input  logic [NUM_PORTS*LEN_W-1:0]     port_len,
  input  logic [NUM_PORTS*USEDW_W-1:0]   fifo_usedw,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [PW-1:0]                  cmd_port,
  output logic                           cmd_wr,
  output logic [ADDR_W-1:0]              cmd_addr,
  output logic [LEN_W-1:0]               cmd_len,
  input  logic                           burst_done,
  output logic [NUM_PORTS*ADDR_W-1:0]    cur_addr,
  output logic                           busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [PW-1:0]     port;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  state_t             state, state_nxt;
  cmd_t               cmd_q;
  logic [PW-1:0]      last_grant, gnt_idx;
  logic               gnt_vld;
  int unsigned        rr_idx;
  logic [NUM_PORTS-1:0] elig;
  logic [ADDR_W-1:0]  cur_arr  [NUM_PORTS];
  logic [LEN_W-1:0]   clip_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sdram_burst_port #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .USEDW_W(USEDW_W),
      .FIFO_DEPTH(FIFO_DEPTH), .IS_WR(PORT_IS_WR[i])
    ) u_port (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .en        (port_en[i]),
      .load      (port_load[i]),
      .base      (port_base[i*ADDR_W +: ADDR_W]),
      .max       (port_max[i*ADDR_W +: ADDR_W]),
      .len       (port_len[i*LEN_W +: LEN_W]),
      .usedw     (fifo_usedw[i*USEDW_W +: USEDW_W]),
      .in_flight (busy && (cmd_q.port == PW'(i))),
      .upd       ((state == WAIT) && burst_done && (cmd_q.port == PW'(i))),
      .burst_len (cmd_q.len),
      .cur       (cur_arr[i]),
      .elig      (elig[i]),
      .clip_len  (clip_arr[i])
    );
    assign cur_addr[i*ADDR_W +: ADDR_W] = cur_arr[i];
  end

  // round-robin: first eligible port after last_grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!gnt_vld && elig[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(rr_idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)    state_nxt = ISSUE;
      ISSUE:   if (cmd_ready)  state_nxt = WAIT;
      WAIT:    if (burst_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ISSUE);
    busy      = (state != IDLE);
    cmd_port  = cmd_q.port;
    cmd_wr    = cmd_q.wr;
    cmd_addr  = cmd_q.addr;
    cmd_len   = cmd_q.len;
  end

  // command fields captured only on grant, so they hold through ISSUE/WAIT
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_q      <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
    end else if (state == IDLE && gnt_vld) begin
      cmd_q      <= '{port: gnt_idx, wr: PORT_IS_WR[gnt_idx],
                      addr: cur_arr[gnt_idx], len: clip_arr[gnt_idx]};
      last_grant <= gnt_idx;
    end
  end
endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler (default parameters:
// 4 ports, ports 0/1 write, ports 2/3 read).
module tb_sdram_burst_scheduler;
  localparam int NP = 4, AW = 23, LW = 9, UW = 10;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic [NP-1:0]      port_en, port_load;
  logic [NP*AW-1:0]   port_base, port_max;
  logic [NP*LW-1:0]   port_len;
  logic [NP*UW-1:0]   fifo_usedw;
  logic               cmd_valid, cmd_ready, cmd_wr, burst_done, busy;
  logic [1:0]         cmd_port;
  logic [AW-1:0]      cmd_addr;
  logic [LW-1:0]      cmd_len;
  logic [NP*AW-1:0]   cur_addr;

  sdram_burst_scheduler dut (
    .CLK(CLK), .RESET_N(RESET_N), .port_en(port_en), .port_load(port_load),
    .port_base(port_base), .port_max(port_max), .port_len(port_len),
    .fifo_usedw(fifo_usedw), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .burst_done(burst_done), .cur_addr(cur_addr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic cfg(input int p, input int base, input int max, input int len, input int usedw);
    port_base[p*AW +: AW]  = AW'(base);
    port_max[p*AW +: AW]   = AW'(max);
    port_len[p*LW +: LW]   = LW'(len);
    fifo_usedw[p*UW +: UW] = UW'(usedw);
  endtask

  function automatic logic [AW-1:0] cur(input int p);
    return cur_addr[p*AW +: AW];
  endfunction

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!cmd_valid && c < 20) begin tick(); c++; end
    chk(tag, cmd_valid, 1);
  endtask

  task automatic done_pulse();
    burst_done = 1'b1; tick(); burst_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int exp_p[5] = '{0, 1, 2, 3, 0};
    int exp_w[5] = '{1, 1, 0, 0, 1};
    int exp_a[5] = '{0, 0, 0, 0, 256};
    RESET_N = 1'b0; port_en = '0; port_load = '0; port_base = '0; port_max = '0;
    port_len = '0; fifo_usedw = '0; cmd_ready = 1'b1; burst_done = 1'b0;
    #12;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_cmd",   {cmd_port, cmd_wr, cmd_addr, cmd_len}, 0);
    chk("rst_cur",   |cur_addr, 0);
    RESET_N = 1'b1;
    tick();

    // round-robin from reset: 0,1,2,3,0
    cfg(0, 0, 307200, 256, 300);
    cfg(1, 5000, 100000, 16, 300);
    cfg(2, 1000, 2000, 256, 0);
    cfg(3, 3000, 4000, 8, 0);
    port_en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("rr_valid%0d", i));
      chk($sformatf("rr_port%0d", i), cmd_port, exp_p[i]);
      chk($sformatf("rr_wr%0d", i),   cmd_wr,   exp_w[i]);
      chk($sformatf("rr_addr%0d", i), cmd_addr, exp_a[i]);
      if (i == 4) port_en = '0;
      tick();
      done_pulse();
    end
    chk("rr_cur3", cur(3), 8);

    // write port 0 basic burst
    cfg(0, 0, 307200, 256, 300);
    port_load = 4'b0001; tick(); port_load = '0;
    chk("ld_cur0", cur(0), 0);
    port_en = 4'b0001;
    tick();
    chk("wr_valid", cmd_valid, 1);
    chk("wr_cmd", {cmd_port, cmd_wr, cmd_addr, cmd_len}, {2'd0, 1'b1, 23'd0, 9'd256});
    tick();
    chk("wr_wait_valid", cmd_valid, 0);
    chk("wr_wait_busy",  busy, 1);
    port_en = '0;
    done_pulse();
    chk("wr_cur0", cur(0), 256);
    chk("wr_idle", busy, 0);

    // stray burst_done in IDLE
    burst_done = 1'b1; tick(); burst_done = 1'b0;
    chk("stray_done_cur0", cur(0), 256);
    chk("stray_done_busy", busy, 0);

    // clip at window end and wrap to base
    cfg(0, 307100, 307200, 256, 300);
    port_load = 4'b0001; tick(); port_load = '0;
    port_base[0 +: AW] = '0;
    port_en = 4'b0001;
    tick();
    chk("clip_valid", cmd_valid, 1);
    chk("clip_addr",  cmd_addr, 307100);
    chk("clip_len",   cmd_len, 100);
    tick();
    port_en = '0;
    done_pulse();
    chk("wrap_cur0", cur(0), 0);

    // load on in-flight port 1
    cfg(1, 5000, 100000, 16, 300);
    port_load = 4'b0010; tick(); port_load = '0;
    port_en = 4'b0010;
    tick();
    chk("pl_port", cmd_port, 1);
    chk("pl_addr", cmd_addr, 5000);
    tick();
    port_load = 4'b0010; tick(); port_load = '0;
    chk("pl_busy", busy, 1);
    chk("pl_cur_hold", cur(1), 5000);
    done_pulse();
    chk("pl_cur_base", cur(1), 5000);
    tick();
    chk("pl_reelig_valid", cmd_valid, 1);
    chk("pl_reelig_addr",  cmd_addr, 5000);
    port_en = '0;
    tick();
    done_pulse();
    chk("pl_cur_inc", cur(1), 5016);

    // read port 2 space check, then stall with cmd_ready low
    cfg(2, 1000, 2000, 256, 300);
    port_load = 4'b0100; tick(); port_load = '0;
    port_en = 4'b0100;
    tick(); tick();
    chk("rd_full_busy",  busy, 0);
    chk("rd_full_valid", cmd_valid, 0);
    fifo_usedw[2*UW +: UW] = 10'd256;
    cmd_ready = 1'b0;
    tick();
    chk("rd_cmd", {cmd_valid, cmd_port, cmd_wr, cmd_addr, cmd_len},
                  {1'b1, 2'd2, 1'b0, 23'd1000, 9'd256});
    fifo_usedw[2*UW +: UW] = 10'd300;
    port_en = '0;
    port_len[2*LW +: LW] = 9'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall%0d", i), {cmd_valid, cmd_port, cmd_wr, cmd_addr, cmd_len},
                                   {1'b1, 2'd2, 1'b0, 23'd1000, 9'd256});
    end
    cmd_ready = 1'b1;
    tick();
    chk("rd_wait_valid", cmd_valid, 0);
    chk("rd_wait_busy",  busy, 1);

    // async reset during WAIT
    RESET_N = 1'b0;
    #1;
    chk("arst_busy",  busy, 0);
    chk("arst_valid", cmd_valid, 0);
    chk("arst_cmd",   {cmd_port, cmd_wr, cmd_addr, cmd_len}, 0);
    chk("arst_cur",   |cur_addr, 0);
    #3;
    RESET_N = 1'b1;
    tick(); tick();
    chk("post_rst_idle", busy, 0);
    port_en = 4'b0011;
    wait_valid("post_rst_valid");
    chk("post_rst_port", cmd_port, 0);
    chk("post_rst_addr", cmd_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_scheduler.md
SDRAM_BURST_SCHEDULER -- requirements
Module: sdram_burst_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of FIFO channels, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 23: SDRAM word-address width.
REQ-003 SHALL have parameter LEN_W, default 9: burst-length width, maximum length 256.
REQ-004 SHALL have parameter USEDW_W, default 10: FIFO fill-level width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 512: per-port FIFO capacity in words.
REQ-006 SHALL have parameter PORT_IS_WR, default 4'b0011: bit i=1 makes port i a write (FIFO-to-SDRAM) port; bit i=0 makes it a read port.
REQ-007 SHALL have port CLK, input, 1: sole clock; all logic on its rising edge.
REQ-008 SHALL have port RESET_N, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port port_en, input, NUM_PORTS: per-port enable.
REQ-010 SHALL have port port_load, input, NUM_PORTS: per-port pulse that reloads the current address from base.
REQ-011 SHALL have port port_base, input, NUM_PORTS*ADDR_W: packed start addresses.
REQ-012 SHALL have port port_max, input, NUM_PORTS*ADDR_W: packed exclusive end addresses.
REQ-013 SHALL have port port_len, input, NUM_PORTS*LEN_W: packed nominal burst lengths.
REQ-014 SHALL have port fifo_usedw, input, NUM_PORTS*USEDW_W: packed FIFO fill levels.
REQ-015 SHALL have port cmd_valid, output, 1: burst request to the command engine.
REQ-016 SHALL have port cmd_ready, input, 1: command engine accepts the request.
REQ-017 SHALL have port cmd_port, output, clog2(NUM_PORTS) (minimum 1): granted port index.
REQ-018 SHALL have port cmd_wr, output, 1: 1=write burst, 0=read burst.
REQ-019 SHALL have port cmd_addr, output, ADDR_W: burst start address.
REQ-020 SHALL have port cmd_len, output, LEN_W: burst length, nonzero.
REQ-021 SHALL have port burst_done, input, 1: single-cycle pulse marking completion of the in-flight burst.
REQ-022 SHALL have port cur_addr, output, NUM_PORTS*ADDR_W: packed per-port current addresses.
REQ-023 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-024 Eligibility SHALL be decided per port: port_en=1, port_len!=0, base<max, and no pending load.
REQ-025 Write-port eligibility SHALL additionally require fifo_usedw >= port_len.
REQ-026 Read-port eligibility SHALL additionally require FIFO_DEPTH - fifo_usedw >= port_len, evaluated at USEDW_W+1 bits with no underflow.
REQ-027 The state machine SHALL have three states, IDLE, ISSUE and WAIT; IDLE moves to ISSUE when at least one port is eligible.
REQ-028 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_PORTS, and last_grant resets to NUM_PORTS-1, so port 0 wins first.
REQ-029 In the IDLE->ISSUE transition, cmd_port, cmd_wr, cmd_addr and cmd_len SHALL be registered, with cmd_valid=1 one cycle after eligibility is seen.
REQ-030 cmd_len SHALL equal min(port_len, max - cur_addr), clipping the burst at the region end.
REQ-031 In ISSUE, cmd_valid and all cmd_* fields SHALL hold stable until cmd_valid&&cmd_ready; the same cycle moves to WAIT with cmd_valid=0.
REQ-032 In WAIT, burst_done SHALL update cur_addr[p] := cur+cmd_len, or base[p] if the result >= max[p], and return to IDLE.
REQ-033 burst_done outside WAIT SHALL be ignored.
REQ-034 When port_load[i] is seen with port i not in flight, cur_addr[i] SHALL become base[i] on the next edge.
REQ-035 When port i is in flight (ISSUE or WAIT), a load SHALL be latched pending and applied at burst_done in place of the increment; a pending load SHALL block eligibility until applied.
REQ-036 Address arithmetic SHALL use ADDR_W+1 bits, so wrap detection holds at the all-ones address.
REQ-037 Deasserting port_en mid-burst SHALL NOT abort the burst; it affects only subsequent arbitration.
REQ-038 The granted port SHALL NOT be rearbitrated before returning to IDLE; one burst is in flight at a time.

Reset
REQ-039 While RESET_N=0: state=IDLE, cmd_valid=0, cmd_port=0, cmd_wr=0, cmd_addr=0, cmd_len=0, busy=0, all cur_addr=0, pending loads cleared, last_grant=NUM_PORTS-1.
REQ-040 Reset assertion mid-burst SHALL abandon the burst immediately; after release, no command SHALL issue until an eligible port appears, and software SHALL pulse port_load to set cur_addr to base.

Verification
REQ-041 Write port 0: base=0, max=640*480, len=256, load, usedw=300, cmd_ready=1 -> cmd_valid one cycle later with addr=0, len=256, wr=1; after burst_done, cur_addr[0]=256.
REQ-042 Wrap and clip: cur_addr=307100, max=307200, len=256 -> cmd_len=100; after done, cur_addr=base.
REQ-043 Round-robin: all four ports eligible and continuously satisfied -> grant order 0,1,2,3,0.
REQ-044 Read port 2: usedw=300, len=256 -> not eligible; usedw=256 -> eligible with cmd_wr=0.
REQ-045 Load on in-flight port 1 during WAIT -> no increment; cur_addr[1]=base[1] after done, and port 1 is eligible again the following cycle.
REQ-046 cmd_ready held low for 10 cycles -> cmd_* stable throughout; RESET_N low during WAIT -> all outputs at reset values asynchronously.
